// File: rtl/bus_burst_master_if.sv
// Bus-side handshake between one burst master and its arbiter slot.
interface bus_burst_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          m_req;
  logic          m_grant;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;

  modport master (
    output m_req,
    output m_wr,
    output m_addr,
    output m_dout,
    input  m_grant
  );

  modport slave (
    input  m_req,
    input  m_wr,
    input  m_addr,
    input  m_dout,
    output m_grant
  );
endinterface

// File: rtl/bus_burst_master.sv
// Burst write master for one arbiter slot: request, wait for grant, issue
// count single-cycle writes with incrementing address/data, release.
// Optional grant-wait timeout is built when BURST_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// REQ    | m_req raised, waiting for grant (optionally time-limited)
// XFER   | one beat per granted cycle until count beats issued
// DONE   | one-cycle done pulse (err too if the grant wait timed out)
module bus_burst_master #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int LW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [LW-1:0]       count,
  input  logic [DW-1:0]       seed,
  bus_burst_master_if.master  m_bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_cnt;

  logic w_accept;
  logic w_beat;
  logic w_last;
  logic w_wait_hit;

  assign w_accept = (r_state == S_IDLE) && start && (count != '0);
  assign w_beat   = (r_state == S_XFER) && m_bus.m_grant;
  assign w_last   = (r_idx == (r_cnt - LW'(1)));

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait;
  logic          r_err;

  assign w_wait_hit = (r_state == S_REQ) && !m_bus.m_grant && (r_wait == '0);

  // Grant-wait down-counter, reloaded on every entry to REQ; err flag held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wait <= TW'(TIMEOUT - 1);
      end else if ((r_state == S_REQ) && !m_bus.m_grant && (r_wait != '0)) begin
        r_wait <= r_wait - TW'(1);
      end
      if (w_wait_hit) begin
        r_err <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err = (r_state == S_DONE) && r_err;
`else
  assign w_wait_hit = 1'b0;
  assign err        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (count != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (m_bus.m_grant) begin
          w_next = S_XFER;
        end else if (w_wait_hit) begin
          w_next = S_DONE;
        end
      end
      S_XFER: begin
        if (w_beat && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Burst datapath: latch command on accept, advance on each beat.
  // The final beat leaves addr/data on the last issued values so the
  // bus keeps showing the last beat while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_addr <= base_addr;
      r_data <= seed;
      r_idx  <= '0;
      r_cnt  <= count;
    end else if (w_beat) begin
      r_idx <= r_idx + LW'(1);
      if (!w_last) begin
        r_addr <= r_addr + AW'(1);
        r_data <= r_data + DW'(1);
      end
    end
  end

  assign m_bus.m_req  = (r_state == S_REQ) || (r_state == S_XFER);
  assign m_bus.m_wr   = w_beat;
  assign m_bus.m_addr = r_addr;
  assign m_bus.m_dout = r_data;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_bus_burst_master.sv
// Self-checking bench for bus_burst_master. Grant patterns are chosen per
// burst; expected beat cycles/addresses/data come from a cycle-count model
// of the request/grant protocol.
module tb_bus_burst_master;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int TIMEOUT = 16;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] count;
  logic [DW-1:0] seed;
  logic          busy, done, err;

  bus_burst_master_if #(.AW(AW), .DW(DW)) bus ();

  bus_burst_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .seed      (seed),
    .m_bus     (bus.master),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit            g_pat [0:MAXC-1];
  logic [AW-1:0] addr_trace [0:MAXC-1];
  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];
  int            obs_cyc [$];
  int            exp_cyc [$];
  int            req_first, req_last, req_n, done_cyc, err_n, exp_done;
  bit            run_tmo, busy0, done0, exp_err;

  // Drive one command at cycle 0 and record bus activity until done.
  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] n,
                           input logic [DW-1:0] s, input bit junk);
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    req_first = -1; req_last = -1; req_n = 0; done_cyc = -1; err_n = 0;
    run_tmo = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      start       = (c == 0) || (junk && c == 3);
      base_addr   = (c == 0) ? b : ~b;
      count       = (c == 0) ? n : LW'(7);
      seed        = (c == 0) ? s : ~s;
      bus.m_grant = g_pat[c];
      #1;
      addr_trace[c] = bus.m_addr;
      if (c == 0) begin busy0 = busy; done0 = done; end
      if (bus.m_req) begin
        req_n++;
        if (req_first < 0) req_first = c;
        req_last = c;
      end
      if (bus.m_wr) begin
        obs_addr.push_back(bus.m_addr);
        obs_data.push_back(bus.m_dout);
        obs_cyc.push_back(c);
      end
      if (err) err_n++;
      if (done) begin done_cyc = c; run_tmo = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  // Protocol model: REQ from cycle 1 until the first grant (or the wait limit),
  // then a beat on each granted cycle after that until n beats, done after last.
  task automatic model(input int n);
    int t0;
    int c;
    exp_cyc.delete();
    exp_err = 1'b0;
    if (n == 0) begin exp_done = 1; return; end
    t0 = -1;
    for (int k = 1; k < MAXC; k++) begin
      if (g_pat[k]) begin t0 = k; break; end
`ifdef BURST_TIMEOUT_EN
      if (k == TIMEOUT) begin exp_err = 1'b1; exp_done = TIMEOUT + 1; return; end
`endif
    end
    c = t0 + 1;
    while (exp_cyc.size() < n && c < MAXC) begin
      if (g_pat[c]) exp_cyc.push_back(c);
      c++;
    end
    exp_done = exp_cyc[exp_cyc.size()-1] + 1;
  endtask

  task automatic fill_grant(input int mode);
    for (int c = 0; c < MAXC; c++)
      g_pat[c] = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; seed = '0; bus.m_grant = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({bus.m_req, bus.m_wr, busy, done, err} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctl: got req/wr/busy/done/err=%b want 00000",
                        {bus.m_req, bus.m_wr, busy, done, err}); end
    n_cmp++; if (bus.m_addr !== '0 || bus.m_dout !== '0) begin
      n_bad++; $display("FAIL reset_bus: got addr=%h dout=%h want 0/0", bus.m_addr, bus.m_dout); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    fill_grant(1);
    run_burst(8'h10, 8'd4, 32'h100, 1'b0);
    n_cmp++; if (obs_cyc.size() != 4) begin
      n_bad++; $display("FAIL basic_nbeats: got %0d want 4", obs_cyc.size()); end
    for (int k = 0; k < obs_cyc.size() && k < 4; k++) begin
      n_cmp++; if (obs_cyc[k] != k + 2 || obs_addr[k] !== AW'(8'h10 + k) || obs_data[k] !== DW'(32'h100 + k)) begin
        n_bad++; $display("FAIL basic_beat%0d: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                          k, obs_cyc[k], obs_addr[k], obs_data[k], k + 2, 8'h10 + k, 32'h100 + k); end
    end
    n_cmp++; if (done_cyc != 6 || req_first != 1 || req_last != 5 || req_n != 5) begin
      n_bad++; $display("FAIL basic_timing: got done=%0d req=%0d..%0d (%0d) want done=6 req=1..5 (5)",
                        done_cyc, req_first, req_last, req_n); end
    // Next command lands on cycle N+3 and must be accepted immediately.
    run_burst(8'h40, 8'd1, 32'h7, 1'b0);
    n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0 || obs_cyc.size() != 1 || done_cyc != 3) begin
      n_bad++; $display("FAIL back_to_back: got busy0=%b done0=%b beats=%0d done=%0d want 0 0 1 3",
                        busy0, done0, obs_cyc.size(), done_cyc); end
  endtask

  task automatic test_zero_count();
    fill_grant(1);
    run_burst(8'h55, 8'd0, 32'h1, 1'b0);
    n_cmp++; if (done_cyc != 1 || req_n != 0 || obs_cyc.size() != 0 || err_n != 0) begin
      n_bad++; $display("FAIL zero_count: got done=%0d req=%0d beats=%0d err=%0d want 1 0 0 0",
                        done_cyc, req_n, obs_cyc.size(), err_n); end
  endtask

  task automatic test_grant_stall();
    fill_grant(1);
    g_pat[3] = 1'b0; g_pat[4] = 1'b0;
    run_burst(8'h20, 8'd3, 32'hABC, 1'b0);
    n_cmp++; if (obs_cyc.size() != 3) begin
      n_bad++; $display("FAIL stall_nbeats: got %0d want 3", obs_cyc.size()); end
    else begin
      n_cmp++; if (obs_cyc[0] != 2 || obs_cyc[1] != 5 || obs_cyc[2] != 6) begin
        n_bad++; $display("FAIL stall_cycles: got %0d,%0d,%0d want 2,5,6", obs_cyc[0], obs_cyc[1], obs_cyc[2]); end
      n_cmp++; if (obs_addr[2] !== 8'h22 || obs_data[2] !== 32'hABE) begin
        n_bad++; $display("FAIL stall_last: got %h/%h want 22/abe", obs_addr[2], obs_data[2]); end
    end
    n_cmp++; if (addr_trace[3] !== 8'h21 || addr_trace[4] !== 8'h21 || done_cyc != 7 || req_last != 6) begin
      n_bad++; $display("FAIL stall_hold: got addr3=%h addr4=%h done=%0d req_last=%0d want 21 21 7 6",
                        addr_trace[3], addr_trace[4], done_cyc, req_last); end
  endtask

  task automatic test_wrap();
    fill_grant(1);
    run_burst(8'hFE, 8'd3, 32'hFFFF_FFFE, 1'b0);
    n_cmp++; if (obs_cyc.size() != 3) begin
      n_bad++; $display("FAIL wrap_nbeats: got %0d want 3", obs_cyc.size()); end
    else begin
      n_cmp++; if (obs_addr[0] !== 8'hFE || obs_addr[1] !== 8'hFF || obs_addr[2] !== 8'h00) begin
        n_bad++; $display("FAIL wrap_addr: got %h %h %h want fe ff 00", obs_addr[0], obs_addr[1], obs_addr[2]); end
      n_cmp++; if (obs_data[0] !== 32'hFFFF_FFFE || obs_data[1] !== 32'hFFFF_FFFF || obs_data[2] !== 32'h0) begin
        n_bad++; $display("FAIL wrap_data: got %h %h %h want fffffffe ffffffff 0",
                          obs_data[0], obs_data[1], obs_data[2]); end
    end
    n_cmp++; if (err_n != 0) begin
      n_bad++; $display("FAIL wrap_err: got %0d err pulses want 0", err_n); end
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    logic [LW-1:0] n;
    logic [DW-1:0] s;
    bit            ok;
    for (int it = 0; it < 24; it++) begin
      b = AW'($urandom); s = $urandom;
      n = LW'($urandom_range(0, 40));
      fill_grant(2);
      model(int'(n));
      run_burst(b, n, s, it[0]);
      n_cmp++; if (run_tmo || done_cyc != exp_done || obs_cyc.size() != exp_cyc.size()) begin
        n_bad++; $display("FAIL rand%0d_shape: got done=%0d beats=%0d want done=%0d beats=%0d",
                          it, done_cyc, obs_cyc.size(), exp_done, exp_cyc.size()); end
      else begin
        ok = 1'b1;
        for (int k = 0; k < exp_cyc.size(); k++)
          if (obs_cyc[k] != exp_cyc[k] || obs_addr[k] !== AW'(b + k) || obs_data[k] !== DW'(s + k)) ok = 1'b0;
        n_cmp++; if (!ok) begin
          n_bad++; $display("FAIL rand%0d_beats: beat cycle/addr/data differ from model (base=%h n=%0d seed=%h)",
                            it, b, n, s); end
      end
      n_cmp++; if (busy0 !== 1'b0 || err_n != int'(exp_err) || req_n != ((n == 0) ? 0 : exp_done - 1)) begin
        n_bad++; $display("FAIL rand%0d_ctl: got busy0=%b err=%0d req=%0d want 0 %0d %0d", it, busy0, err_n,
                          req_n, int'(exp_err), (n == 0) ? 0 : exp_done - 1); end
    end
  endtask

  task automatic test_reset_mid();
    fill_grant(1);
    @(negedge clk);
    start = 1'b1; base_addr = 8'h80; count = 8'd10; seed = 32'h5; bus.m_grant = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.m_wr !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: got m_wr=%b want 1", bus.m_wr); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if ({bus.m_req, bus.m_wr, busy, done, err} !== 5'b0 || bus.m_addr !== '0 || bus.m_dout !== '0) begin
      n_bad++; $display("FAIL rstmid_out: got req/wr/busy/done/err=%b addr=%h dout=%h want all 0",
                        {bus.m_req, bus.m_wr, busy, done, err}, bus.m_addr, bus.m_dout); end
    reset = 1'b0;
    run_burst(8'h30, 8'd2, 32'h9, 1'b0);
    n_cmp++; if (obs_cyc.size() != 2 || done_cyc != 4 || obs_addr[0] !== 8'h30 || obs_data[1] !== 32'hA) begin
      n_bad++; $display("FAIL rstmid_after: got beats=%0d done=%0d want 2 beats done=4 addr 30 data a",
                        obs_cyc.size(), done_cyc); end
  endtask

`ifdef BURST_TIMEOUT_EN
  task automatic test_timeout();
    fill_grant(0);
    run_burst(8'h11, 8'd5, 32'h1, 1'b0);
    n_cmp++; if (run_tmo || done_cyc != TIMEOUT + 1 || req_last != TIMEOUT || req_n != TIMEOUT) begin
      n_bad++; $display("FAIL timeout_timing: got done=%0d req_last=%0d req=%0d want %0d %0d %0d",
                        done_cyc, req_last, req_n, TIMEOUT + 1, TIMEOUT, TIMEOUT); end
    n_cmp++; if (err_n != 1 || obs_cyc.size() != 0) begin
      n_bad++; $display("FAIL timeout_err: got err=%0d beats=%0d want 1 0", err_n, obs_cyc.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_grant_stall();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef BURST_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
